// File: rtl/matmul_seq_ctrl_if.sv
// Bundle of host-side and core-side signals for the matrix-multiply sequencer.
// The slave modport is the sequencer. The master modport is whoever drives the host and core.
interface matmul_seq_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int RES_W  = 512,
  parameter int ADDR_W = 1
);
  logic              Start;
  logic [DATA_W-1:0] A_data;
  logic [DATA_W-1:0] B_data;
  logic [DATA_W-1:0] MA_dib;
  logic [DATA_W-1:0] MB_dib;
  logic [ADDR_W-1:0] MA_Addrb;
  logic [ADDR_W-1:0] MB_Addrb;
  logic              MA_enb;
  logic              MA_web;
  logic              MB_enb;
  logic              MB_web;
  logic              Rst_M;
  logic              Rst_Core;
  logic              Go;
  logic              Core_Done;
  logic [RES_W-1:0]  Core_Result;
  logic [RES_W-1:0]  Result;
  logic              Result_Valid;
  logic              Busy;
  logic              Timeout_Err;

  modport slave (
    input  Start, A_data, B_data, Core_Done, Core_Result,
    output MA_dib, MB_dib, MA_Addrb, MB_Addrb, MA_enb, MA_web, MB_enb, MB_web,
           Rst_M, Rst_Core, Go, Result, Result_Valid, Busy, Timeout_Err
  );

  modport master (
    output Start, A_data, B_data, Core_Done, Core_Result,
    input  MA_dib, MB_dib, MA_Addrb, MB_Addrb, MA_enb, MA_web, MB_enb, MB_web,
           Rst_M, Rst_Core, Go, Result, Result_Valid, Busy, Timeout_Err
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 4x4 matrix-multiply core: it loads the operands, pulses Go, and waits for Done or a timeout.
// Every control output is registered from the decode of the next state, so it matches the current state.
module matmul_seq_ctrl #(
  parameter int DATA_W  = 128,
  parameter int RES_W   = 512,
  parameter int ADDR_W  = 1,
  parameter int TIMEOUT = 1000
) (
  input  logic               Clk,
  input  logic               Rst,
  matmul_seq_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_IDLE = 3'd1, S_WR_A = 3'd2, S_WR_B = 3'd3,
    S_GO   = 3'd4, S_WAIT = 3'd5, S_DONE = 3'd6, S_ERR  = 3'd7
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] ma_dib_q, ma_dib_d;
  logic [DATA_W-1:0] mb_dib_q, mb_dib_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              terr_q, terr_d;
  logic              ma_we_q, ma_we_d;
  logic              mb_we_q, mb_we_d;
  logic              go_q, go_d;
  logic              rst_m_q, rst_m_d;
  logic              rst_core_q, rst_core_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  // Next-state, datapath capture and the wait counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    ma_dib_d = ma_dib_q;
    mb_dib_d = mb_dib_q;
    result_d = result_q;
    terr_d   = terr_q;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (bus.Start) begin
          state_d  = S_WR_A;
          ma_dib_d = bus.A_data;
          b_d      = bus.B_data;
          terr_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_A: begin
        state_d  = S_WR_B;
        mb_dib_d = b_q;
      end
      S_WR_B: state_d = S_GO;
      S_GO: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // Done wins over a timeout that expires in the same cycle.
        if (bus.Core_Done) begin
          result_d = bus.Core_Result;
          state_d  = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        terr_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Moore decode of the state being entered; the result is registered below.
  always_comb begin
    ma_we_d    = 1'b0;
    mb_we_d    = 1'b0;
    go_d       = 1'b0;
    rst_m_d    = 1'b0;
    rst_core_d = 1'b1;
    busy_d     = 1'b1;
    valid_d    = 1'b0;
    case (state_d)
      S_INIT: rst_m_d = 1'b1;
      S_IDLE: busy_d  = 1'b0;
      S_WR_A: ma_we_d = 1'b1;
      S_WR_B: mb_we_d = 1'b1;
      S_GO: begin
        rst_core_d = 1'b0;
        go_d       = 1'b1;
      end
      S_WAIT: rst_core_d = 1'b0;
      S_DONE: valid_d    = 1'b1;
      S_ERR:  rst_core_d = 1'b1;
      default: rst_m_d   = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_INIT;
      cnt_q      <= 16'd0;
      b_q        <= '0;
      ma_dib_q   <= '0;
      mb_dib_q   <= '0;
      result_q   <= '0;
      terr_q     <= 1'b0;
      ma_we_q    <= 1'b0;
      mb_we_q    <= 1'b0;
      go_q       <= 1'b0;
      rst_m_q    <= 1'b1;
      rst_core_q <= 1'b1;
      busy_q     <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b_q        <= b_d;
      ma_dib_q   <= ma_dib_d;
      mb_dib_q   <= mb_dib_d;
      result_q   <= result_d;
      terr_q     <= terr_d;
      ma_we_q    <= ma_we_d;
      mb_we_q    <= mb_we_d;
      go_q       <= go_d;
      rst_m_q    <= rst_m_d;
      rst_core_q <= rst_core_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.MA_dib       = ma_dib_q;
  assign bus.MB_dib       = mb_dib_q;
  assign bus.MA_Addrb     = {ADDR_W{1'b0}};
  assign bus.MB_Addrb     = {ADDR_W{1'b0}};
  assign bus.MA_enb       = ma_we_q;
  assign bus.MA_web       = ma_we_q;
  assign bus.MB_enb       = mb_we_q;
  assign bus.MB_web       = mb_we_q;
  assign bus.Go           = go_q;
  assign bus.Rst_M        = rst_m_q;
  assign bus.Rst_Core     = rst_core_q;
  assign bus.Busy         = busy_q;
  assign bus.Result_Valid = valid_q;
  assign bus.Result       = result_q;
  assign bus.Timeout_Err  = terr_q;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl (TIMEOUT=8): reset, table vectors, reset in WAIT, and random operations.
// The expected timeline and product are derived from the operation rules. The DUT is never read back for them.
module tb_matmul_seq_ctrl;
  localparam int TO = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] m_mb;
  logic [511:0] m_res;
  logic         m_terr;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    int           d;
    bit           hold;
    int           exp_lat;
  } vec_t;

  matmul_seq_ctrl_if #(.DATA_W(128), .RES_W(512), .ADDR_W(1)) bus ();

  matmul_seq_ctrl #(.DATA_W(128), .RES_W(512), .ADDR_W(1), .TIMEOUT(TO)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [511:0] matmul(input logic [127:0] a, input logic [127:0] b);
    logic [511:0] r;
    logic [31:0]  acc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 32'd0;
        for (int k = 0; k < 4; k++) begin
          acc += 32'(a[(i*4+k)*8 +: 8]) * 32'(b[(k*4+j)*8 +: 8]);
        end
        r[(i*4+j)*32 +: 32] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [9:0] mk_ctrl(input bit ma, input bit mb, input bit go, input bit rc,
                                         input bit rm, input bit busy, input bit vld, input bit te);
    return {ma, ma, mb, mb, go, rc, rm, busy, vld, te};
  endfunction

  function automatic logic [9:0] act_ctrl();
    return {bus.MA_enb, bus.MA_web, bus.MB_enb, bus.MB_web, bus.Go, bus.Rst_Core,
            bus.Rst_M, bus.Busy, bus.Result_Valid, bus.Timeout_Err};
  endfunction

  // Latency from Start edge to the Result_Valid cycle, or 0 when the op must time out.
  function automatic int model_lat(input int d);
    return (d >= 1 && d <= TO) ? 4 + d : 0;
  endfunction

  task automatic chk(input string name, input int t, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d act=%0h exp=%0h", name, t, act, exp);
    end
  endtask

  // One operation: Start at this negedge, then check every cycle until the first IDLE cycle.
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input int d,
                        input bit hold, input int exp_lat);
    bit           tmo;
    int           last, end_wait;
    logic [511:0] prod;
    bit           noise_ok;
    tmo      = (exp_lat == 0);
    last     = tmo ? 13 : exp_lat + 1;
    end_wait = tmo ? 3 + TO : exp_lat - 1;
    prod     = matmul(a, b);
    chk("pre_busy", 0, 512'(bus.Busy), 512'd0);
    chk("pre_terr", 0, 512'(bus.Timeout_Err), 512'(m_terr));
    chk("pre_result", 0, bus.Result, m_res);
    bus.Start  = 1'b1;
    bus.A_data = a;
    bus.B_data = b;
    for (int t = 1; t <= last; t++) begin
      @(negedge Clk);
      chk("ctrl", t, 512'(act_ctrl()),
          512'(mk_ctrl(t == 1, t == 2, t == 3, !(t >= 3 && t <= end_wait), 1'b0,
                       tmo ? (t <= 12) : (t <= exp_lat), !tmo && t == exp_lat, tmo && t >= 13)));
      chk("addrb", t, 512'({bus.MA_Addrb, bus.MB_Addrb}), 512'd0);
      chk("ma_dib", t, 512'(bus.MA_dib), 512'(a));
      chk("mb_dib", t, 512'(bus.MB_dib), 512'((t >= 2) ? b : m_mb));
      chk("result", t, bus.Result, (!tmo && t >= exp_lat) ? prod : m_res);
      bus.A_data = rand128();
      bus.B_data = rand128();
      bus.Start  = (t < last) ? (hold ? 1'b1 : ($urandom_range(0, 3) == 0)) : hold;
      noise_ok   = (t < 4) || (t > 3 + TO) || (d >= 1 && d <= TO && t > 3 + d);
      if (d > 0 && t == 3 + d) begin
        bus.Core_Done   = 1'b1;
        bus.Core_Result = prod;
      end else begin
        bus.Core_Done   = noise_ok ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.Core_Result = rand512();
      end
    end
    m_mb   = b;
    m_terr = tmo;
    if (!tmo) m_res = prod;
  endtask

  vec_t vecs[8];

  initial begin
    bus.Start       = 1'b0;
    bus.A_data      = '0;
    bus.B_data      = '0;
    bus.Core_Done   = 1'b0;
    bus.Core_Result = '0;
    m_mb   = '0;
    m_res  = '0;
    m_terr = 1'b0;

    vecs[0] = '{128'h0102030405060708090A0B0C0D0E0F10, 128'h01000000000100000000010000000001, 6, 1'b0, 10};
    vecs[1] = '{128'hFFEEDDCCBBAA99887766554433221100, 128'h0F0E0D0C0B0A09080706050403020100, 1, 1'b0, 5};
    vecs[2] = '{128'h11223344556677881122334455667788, 128'h80808080808080808080808080808080, 8, 1'b0, 12};
    vecs[3] = '{128'h0A0B0C0D0E0F10111213141516171819, 128'h01010101010101010101010101010101, 0, 1'b0, 0};
    vecs[4] = '{128'h00000000000000000000000000000001, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 3, 1'b0, 7};
    vecs[5] = '{128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 9, 1'b0, 0};
    vecs[6] = '{128'h0102010201020102010201020102A0B0, 128'h030303030303030303030303030303FF, 2, 1'b1, 6};
    vecs[7] = '{128'hDEADBEEFCAFEF00D0123456789ABCDEF, 128'h00112233445566778899AABBCCDDEEFF, 5, 1'b1, 9};

    // Reset held three cycles, then INIT for exactly one cycle before IDLE.
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_init_ctrl", 1, 512'(act_ctrl()), 512'(mk_ctrl(0, 0, 0, 1, 1, 1, 0, 0)));
    chk("rst_result", 1, bus.Result, 512'd0);
    chk("rst_dib", 1, 512'({bus.MA_dib, bus.MB_dib}), 512'd0);
    @(negedge Clk);
    chk("rst_idle_ctrl", 2, 512'(act_ctrl()), 512'(mk_ctrl(0, 0, 0, 1, 0, 0, 0, 0)));

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].hold, vecs[i].exp_lat);
    end

    // Reset in WAIT, with Done coinciding with Rst and again in INIT.
    bus.Start  = 1'b1;
    bus.A_data = rand128();
    bus.B_data = rand128();
    for (int t = 1; t <= 6; t++) begin
      @(negedge Clk);
      bus.Start     = 1'b0;
      bus.Core_Done = 1'b0;
    end
    chk("wait_go_low", 6, 512'(bus.Go), 512'd0);
    Rst             = 1'b1;
    bus.Core_Done   = 1'b1;
    bus.Core_Result = rand512();
    @(negedge Clk);
    chk("rstw_init_ctrl", 7, 512'(act_ctrl()), 512'(mk_ctrl(0, 0, 0, 1, 1, 1, 0, 0)));
    chk("rstw_result", 7, bus.Result, 512'd0);
    chk("rstw_dib", 7, 512'({bus.MA_dib, bus.MB_dib}), 512'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rstw_idle_ctrl", 8, 512'(act_ctrl()), 512'(mk_ctrl(0, 0, 0, 1, 0, 0, 0, 0)));
    chk("rstw_idle_result", 8, bus.Result, 512'd0);
    bus.Core_Done = 1'b0;
    m_res  = '0;
    m_mb   = '0;
    m_terr = 1'b0;
    run_op(128'h0102030405060708090A0B0C0D0E0F10, 128'h01000000000100000000010000000001, 4, 1'b0, 8);

    // Random operations against the rule-based model, with occasional idle gaps.
    for (int n = 0; n < 30; n++) begin
      int d;
      d = $urandom_range(0, TO + 2);
      run_op(rand128(), rand128(), d, 1'($urandom_range(0, 3) == 0), model_lat(d));
      if ($urandom_range(0, 2) == 0) begin
        bus.Start = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge Clk);
          chk("gap_ctrl", 0, 512'(act_ctrl()), 512'(mk_ctrl(0, 0, 0, 1, 0, 0, 0, m_terr)));
        end
      end
    end

    bus.Start = 1'b0;
    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
